imm_expander: RTL and testbench

IMM_EXPANDER -- requirements
Module: imm_expander

---
 rtl/imm_expander.sv | 93 +++++++++
 tb/tb_imm_expander.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/imm_expander.sv
// Expands a 32-bit load-constant request into one or two MIPS I-type words (ADDIU / ORI / LUI+ORI).
// Optional IMM_ZERO_LO_OPT_EN: drop the trailing ORI when the low half of a LUI-class constant is zero.
module imm_expander (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [4:0]  rt_i,
    input  logic [31:0] imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_last_o
);
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    state_t      state_q;
    logic [31:0] instr_q;
    logic        last_q;
    logic [31:0] second_q;

    logic [31:0] first_d;
    logic [31:0] second_d;
    logic        two_d;

    // Encoding is chosen from the request inputs; it is latched only on acceptance.
    always_comb begin
        first_d  = {OP_ADDIU, 5'd0, rt_i, imm_i[15:0]};
        second_d = '0;
        two_d    = 1'b0;
        if (&imm_i[31:15] || ~|imm_i[31:15]) begin
            first_d = {OP_ADDIU, 5'd0, rt_i, imm_i[15:0]};
        end else if (~|imm_i[31:16]) begin
            first_d = {OP_ORI, 5'd0, rt_i, imm_i[15:0]};
        end else begin
            first_d  = {OP_LUI, 5'd0, rt_i, imm_i[31:16]};
            second_d = {OP_ORI, rt_i, rt_i, imm_i[15:0]};
`ifdef IMM_ZERO_LO_OPT_EN
            two_d    = |imm_i[15:0];
`else
            two_d    = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            last_q   <= 1'b0;
            second_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    state_q  <= EMIT1;
                    instr_q  <= first_d;
                    last_q   <= ~two_d;
                    second_q <= second_d;
                end
                EMIT1: if (instr_ready_i) begin
                    if (!last_q) begin
                        state_q <= EMIT2;
                        instr_q <= second_q;
                        last_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        instr_q <= '0;
                        last_q  <= 1'b0;
                    end
                end
                EMIT2: if (instr_ready_i) begin
                    state_q <= IDLE;
                    instr_q <= '0;
                    last_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    instr_q <= '0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign instr_valid_o = (state_q != IDLE);
    assign instr_o       = instr_q;
    assign instr_last_o  = last_q;
endmodule

// File: tb/tb_imm_expander.sv
// Randomized self-checking bench for imm_expander against an arithmetic model of the expansion rules.
module tb_imm_expander;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [4:0]  rt_i;
    logic [31:0] imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        instr_last_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    imm_expander dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rt_i(rt_i), .imm_i(imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_last_o(instr_last_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Model: classify the constant numerically and build the word list.
    function automatic void model(input logic [4:0] rt, input logic [31:0] imm);
        longint sv = longint'($signed(imm));
        longint unsigned r  = rt;
        longint unsigned lo = imm % 65536;
        longint unsigned hi = imm / 65536;
        bit opt = 0;
`ifdef IMM_ZERO_LO_OPT_EN
        opt = 1;
`endif
        exp_q.delete();
        if (sv >= -32768 && sv <= 32767)
            exp_q.push_back(32'((9 << 26) + (r << 16) + lo));
        else if (imm < 32'd65536)
            exp_q.push_back(32'((13 << 26) + (r << 16) + lo));
        else begin
            exp_q.push_back(32'((15 << 26) + (r << 16) + hi));
            if (!(opt && lo == 0))
                exp_q.push_back(32'((13 << 26) + (r << 21) + (r << 16) + lo));
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_instr"}, instr_o, 32'd0);
        chk({tag, "_last"}, 32'(instr_last_o), 32'd0);
    endtask

    // Issue one request and drain it; nstall forced stall cycles per word, then random stalls.
    task automatic run(input logic [4:0] rt, input logic [31:0] imm, input int nstall, input bit rnd);
        int n;
        bit rdy;
        model(rt, imm);
        chk("req_ready_pre", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; rt_i = rt; imm_i = imm; instr_ready_i = 1'($urandom);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n = 0;
            do begin
                chk("valid", 32'(instr_valid_o), 32'd1);
                chk("instr", instr_o, exp_q[i]);
                chk("last", 32'(instr_last_o), 32'(i == exp_q.size() - 1));
                chk("req_ready_busy", 32'(req_ready_o), 32'd0);
                if (n < nstall)       rdy = 1'b0;
                else if (rnd && n < 20) rdy = ($urandom_range(3) != 0);
                else                  rdy = 1'b1;
                instr_ready_i = rdy;
                req_valid_i = (rdy && i == exp_q.size() - 1) ? 1'b0 : 1'($urandom);
                rt_i = 5'($urandom); imm_i = $urandom;
                tick();
                n++;
            end while (!rdy);
        end
        req_valid_i = 1'b0; instr_ready_i = 1'b0;
        check_idle("post");
    endtask

    initial begin
        int sel;
        logic [31:0] v;
        reset = 1'b1; req_valid_i = 1'b1; rt_i = 5'd3; imm_i = 32'h12345678; instr_ready_i = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0; req_valid_i = 1'b0;
        tick();
        check_idle("idle");

        run(5'd8,  32'hFFFF8000, 0, 0);
        run(5'd9,  32'h0000ABCD, 0, 0);
        run(5'd10, 32'h12345678, 0, 0);
        run(5'd4,  32'h00010000, 0, 0);
        run(5'd0,  32'h00000000, 0, 0);
        run(5'd0,  32'h00007FFF, 0, 0);
        run(5'd31, 32'h00008000, 1, 0);
        run(5'd31, 32'hFFFF7FFF, 0, 0);
        run(5'd10, 32'h12345678, 3, 0);

        // Reset while the second word of a LUI/ORI pair is pending.
        model(5'd10, 32'h12345678);
        req_valid_i = 1'b1; rt_i = 5'd10; imm_i = 32'h12345678; instr_ready_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        chk("rst_w1", instr_o, exp_q[0]);
        tick();
        chk("rst_w2_valid", 32'(instr_valid_o), 32'd1);
        chk("rst_w2", instr_o, exp_q[1]);
        reset = 1'b1; req_valid_i = 1'b1; imm_i = 32'h00000005; instr_ready_i = 1'b0;
        tick();
        reset = 1'b0; req_valid_i = 1'b0;
        check_idle("rst_emit2");
        tick();
        check_idle("rst_after");

        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(4);
            v = $urandom;
            case (sel)
                0: v = {{17{v[15]}}, v[14:0]};
                1: v = {16'h0000, v[15:0]};
                2: v = {v[31:16], 16'h0000};
                default: ;
            endcase
            run(5'($urandom), v, $urandom_range(2), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
